// File: rtl/store_translate_stage_pkg.sv
// Shared types and helpers for the store translation stage: store sizes,
// exception cause codes, byte-enable generation and lane alignment.
package store_translate_stage_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } st_size_e;

    localparam logic [63:0] STORE_ADDR_MISALIGNED = 64'd6;

    function automatic logic [7:0] be_gen(input st_size_e size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            SIZE_WORD: base = 8'h0F;
            default:   base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] data_align(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic is_misaligned(input st_size_e size, input logic [2:0] off);
        case (size)
            SIZE_HALF: return off[0] != 1'b0;
            SIZE_WORD: return off[1:0] != 2'b00;
            SIZE_DWORD: return off != 3'b000;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_translate_stage.sv
// Store path front end: accepts one store, checks alignment, translates via the
// DTLB, pushes into the store buffer and reports completion on writeback.
module store_translate_stage
    import store_translate_stage_pkg::*;
#(
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [63:0]              vaddr_i,
    input  logic [63:0]              data_i,
    input  logic [1:0]               size_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [13:0]              signature_i,
    output logic                     translation_req_o,
    output logic [63:0]              vaddr_o,
    input  logic                     dtlb_hit_i,
    input  logic [63:0]              paddr_i,
    input  logic                     dtlb_ex_valid_i,
    input  logic [63:0]              dtlb_ex_cause_i,
    output logic                     sb_valid_o,
    output logic                     sb_valid_without_flush_o,
    input  logic                     sb_ready_i,
    output logic [63:0]              sb_paddr_o,
    output logic [63:0]              sb_data_o,
    output logic [7:0]               sb_be_o,
    output logic [1:0]               sb_size_o,
    output logic [13:0]              sb_signature_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     wb_ex_valid_o,
    output logic [63:0]              wb_ex_cause_o,
    output logic [63:0]              wb_ex_tval_o
);

    typedef enum logic [1:0] {IDLE, XLATE, WAIT_SB, EXC} state_e;

    state_e                   state_q;
    logic [63:0]              vaddr_q;
    logic [63:0]              data_q;
    logic [7:0]               be_q;
    st_size_e                 size_q;
    logic [13:0]              sig_q;
    logic [TRANS_ID_BITS-1:0] trans_id_q;
    logic [63:0]              paddr_q;
    logic [63:0]              cause_q;
    logic                     wb_valid_q;
    logic                     wb_ex_valid_q;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_q;
    logic [63:0]              wb_cause_q;
    logic [63:0]              wb_tval_q;

    logic     hit_ok;
    logic     push;
    st_size_e size_in;

    assign size_in = st_size_e'(size_i);
    assign hit_ok  = (state_q == XLATE) && dtlb_hit_i && !dtlb_ex_valid_i;
    // The store buffer never sees a push in a flush cycle.
    assign push    = (hit_ok || (state_q == WAIT_SB)) && sb_ready_i && !flush_i;

    assign ready_o                  = (state_q == IDLE);
    assign translation_req_o        = (state_q == XLATE);
    assign vaddr_o                  = vaddr_q;
    assign sb_valid_o               = push;
    assign sb_valid_without_flush_o = hit_ok || (state_q == WAIT_SB);
    assign sb_paddr_o               = (state_q == XLATE) ? paddr_i : paddr_q;
    assign sb_data_o                = data_q;
    assign sb_be_o                  = be_q;
    assign sb_size_o                = size_q;
    assign sb_signature_o           = sig_q;
    assign wb_valid_o               = wb_valid_q;
    assign wb_trans_id_o            = wb_trans_id_q;
    assign wb_ex_valid_o            = wb_ex_valid_q;
    assign wb_ex_cause_o            = wb_cause_q;
    assign wb_ex_tval_o             = wb_tval_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            vaddr_q       <= '0;
            data_q        <= '0;
            be_q          <= '0;
            size_q        <= SIZE_BYTE;
            sig_q         <= '0;
            trans_id_q    <= '0;
            paddr_q       <= '0;
            cause_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_ex_valid_q <= 1'b0;
            wb_trans_id_q <= '0;
            wb_cause_q    <= '0;
            wb_tval_q     <= '0;
        end else begin
            wb_valid_q    <= 1'b0;
            wb_ex_valid_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (valid_i) begin
                            vaddr_q    <= vaddr_i;
                            data_q     <= data_align(data_i, vaddr_i[2:0]);
                            be_q       <= be_gen(size_in, vaddr_i[2:0]);
                            size_q     <= size_in;
                            sig_q      <= signature_i;
                            trans_id_q <= trans_id_i;
                            if (is_misaligned(size_in, vaddr_i[2:0])) begin
                                cause_q <= STORE_ADDR_MISALIGNED;
                                state_q <= EXC;
                            end else begin
                                state_q <= XLATE;
                            end
                        end
                    end
                    XLATE: begin
                        if (dtlb_hit_i) begin
                            if (dtlb_ex_valid_i) begin
                                cause_q <= dtlb_ex_cause_i;
                                state_q <= EXC;
                            end else begin
                                paddr_q <= paddr_i;
                                state_q <= push ? IDLE : WAIT_SB;
                            end
                        end
                    end
                    WAIT_SB: begin
                        if (push) state_q <= IDLE;
                    end
                    EXC: begin
                        wb_ex_valid_q <= 1'b1;
                        wb_cause_q    <= cause_q;
                        wb_tval_q     <= vaddr_q;
                        wb_valid_q    <= 1'b1;
                        wb_trans_id_q <= trans_id_q;
                        state_q       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
                if (push) begin
                    wb_valid_q    <= 1'b1;
                    wb_trans_id_q <= trans_id_q;
                    wb_cause_q    <= '0;
                    wb_tval_q     <= '0;
                end
            end
        end
    end

endmodule
